// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: controller FSM states, default timeout and
// the sizing rule for the controller's wait counter.
package wishbone_pkg;

  typedef enum logic {
    WB_CTRL_IDLE,
    WB_CTRL_ACTIVE
  } wb_ctrl_state_t;

  localparam int WB_CTRL_TIMEOUT_DEFAULT = 15;

  // Wait counter width: wide enough to hold TIMEOUT, never narrower than one bit.
  function automatic int wb_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wishbone_ctrl_classic_if.sv
// Request/response handshake plus Wishbone Classic master-side bus for the
// controller adapter. master = controller view, slave = requester/device view.
interface wishbone_ctrl_classic_if #(
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 8
);
  logic                 req;
  logic                 req_ready;
  logic                 req_we;
  logic [ADR_WIDTH-1:0] req_adr;
  logic [DAT_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic [DAT_WIDTH-1:0] resp_rdata;
  logic                 resp_timeout;
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;

  modport master (
    input  req, req_we, req_adr, req_wdata, dat_i, ack_i,
    output req_ready, resp_valid, resp_rdata, resp_timeout,
    output cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output req, req_we, req_adr, req_wdata, dat_i, ack_i,
    input  req_ready, resp_valid, resp_rdata, resp_timeout,
    input  cyc_o, stb_o, we_o, adr_o, dat_o
  );

endinterface

// File: rtl/wishbone_ctrl_classic.sv
// Wishbone B4 Classic controller: one request becomes one read/write bus cycle,
// answered by a single-cycle response pulse carrying read data or a timeout flag.
module wishbone_ctrl_classic
  import wishbone_pkg::*;
#(
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 8,
  parameter int TIMEOUT   = WB_CTRL_TIMEOUT_DEFAULT
) (
  input logic clk_i,
  input logic rst_i,
  wishbone_ctrl_classic_if.master bus
);

  localparam int CNT_W = wb_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  wb_ctrl_state_t       state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic                 timeout_hit;
  logic                 cyc_reg;
  logic                 stb_reg;
  logic                 we_reg;
  logic [ADR_WIDTH-1:0] adr_reg;
  logic [DAT_WIDTH-1:0] dat_reg;
  logic                 resp_valid_reg;
  logic [DAT_WIDTH-1:0] resp_rdata_reg;
  logic                 resp_timeout_reg;

  // Saturating increment so a long stall with the timeout disabled never wraps.
  assign cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TO_CNT);

  assign bus.req_ready    = (state_reg == WB_CTRL_IDLE) && !rst_i;
  assign bus.cyc_o        = cyc_reg;
  assign bus.stb_o        = stb_reg;
  assign bus.we_o         = we_reg;
  assign bus.adr_o        = adr_reg;
  assign bus.dat_o        = dat_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_rdata   = resp_rdata_reg;
  assign bus.resp_timeout = resp_timeout_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= WB_CTRL_IDLE;
      cnt_reg          <= '0;
      cyc_reg          <= 1'b0;
      stb_reg          <= 1'b0;
      we_reg           <= 1'b0;
      adr_reg          <= '0;
      dat_reg          <= '0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      resp_timeout_reg <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        WB_CTRL_IDLE: begin
          if (bus.req) begin
            adr_reg   <= bus.req_adr;
            we_reg    <= bus.req_we;
            dat_reg   <= bus.req_we ? bus.req_wdata : '0;
            cyc_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= WB_CTRL_ACTIVE;
          end
        end
        WB_CTRL_ACTIVE: begin
          // Ack is checked first so an ack on the timeout edge still completes normally.
          if (bus.ack_i) begin
            cyc_reg          <= 1'b0;
            stb_reg          <= 1'b0;
            we_reg           <= 1'b0;
            resp_valid_reg   <= 1'b1;
            resp_rdata_reg   <= we_reg ? '0 : bus.dat_i;
            resp_timeout_reg <= 1'b0;
            state_reg        <= WB_CTRL_IDLE;
          end else begin
            cnt_reg <= cnt_next;
            if (timeout_hit) begin
              cyc_reg          <= 1'b0;
              stb_reg          <= 1'b0;
              we_reg           <= 1'b0;
              resp_valid_reg   <= 1'b1;
              resp_rdata_reg   <= '0;
              resp_timeout_reg <= 1'b1;
              state_reg        <= WB_CTRL_IDLE;
            end
          end
        end
        default: state_reg <= WB_CTRL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_ctrl_classic.sv
// Directed bench for wishbone_ctrl_classic with a small wait-state device model
// and a response scoreboard checked by an independent monitor.
module tb_wishbone_ctrl_classic;
  import wishbone_pkg::*;

  typedef struct packed {
    logic [7:0] rdata;
    logic       to;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_checks = 0;
  int         n_fail = 0;
  resp_t      exp_q[$];

  // Device model: acks in the (wait_n+2)th cycle of a strobe when enabled.
  logic       ack_en = 1'b0;
  logic       force_ack = 1'b0;
  logic [7:0] wait_n = 8'd0;
  logic [7:0] dev_rdata = 8'd0;
  logic [7:0] dev_cnt;

  wishbone_ctrl_classic_if #(.DAT_WIDTH(8), .ADR_WIDTH(8)) bus ();

  wishbone_ctrl_classic #(
    .DAT_WIDTH(8),
    .ADR_WIDTH(8),
    .TIMEOUT(WB_CTRL_TIMEOUT_DEFAULT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.stb_o !== 1'b1) dev_cnt <= 8'd0;
    else dev_cnt <= dev_cnt + 8'd1;
  end

  assign bus.ack_i = force_ack || (ack_en && (bus.stb_o === 1'b1) && (dev_cnt == wait_n + 8'd1));
  assign bus.dat_i = (bus.adr_o == 8'h41) ? 8'hC3 : dev_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%0h timeout=%0b, required no response",
                 bus.resp_rdata, bus.resp_timeout);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
        check("resp_timeout", 32'(bus.resp_timeout), 32'(e.to));
        $display("resp: rdata=0x%02h timeout=%0b (expected 0x%02h/%0b)",
                 bus.resp_rdata, bus.resp_timeout, e.rdata, e.to);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [7:0] adr, input logic [7:0] wdata,
                       input bit push, input resp_t e);
    bus.req       = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_wdata = wdata;
    check("req_ready_at_accept", 32'(bus.req_ready), 32'd1);
    if (push) exp_q.push_back(e);
    $display("req: we=%0b adr=0x%02h wdata=0x%02h", we, adr, wdata);
    tick();
    bus.req = 1'b0;
  endtask

  // Walks the bus cycle from cycle 1, checking stable outputs, then its length.
  task automatic run_bus(input string name, input logic we, input logic [7:0] adr,
                         input logic [7:0] dat, input int exp_len);
    int n = 0;
    while (bus.cyc_o === 1'b1 && n < 40) begin
      check({name, "_adr"}, 32'(bus.adr_o), 32'(adr));
      check({name, "_we"}, 32'(bus.we_o), 32'(we));
      check({name, "_dat"}, 32'(bus.dat_o), 32'(dat));
      check({name, "_stb"}, 32'(bus.stb_o), 32'd1);
      check({name, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      n++;
      tick();
    end
    check({name, "_cyc_len"}, 32'(n), 32'(exp_len));
    check({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({name, "_cyc_after"}, 32'(bus.cyc_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:1] exp_cyc;
    logic [6:1] exp_rdy;
    bus.req = 1'b0;
    bus.req_we = 1'b0;
    bus.req_adr = 8'h00;
    bus.req_wdata = 8'h00;

    // Reset state
    tick(); tick(); tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("rst_stb", 32'(bus.stb_o), 32'd0);
    check("rst_we", 32'(bus.we_o), 32'd0);
    check("rst_adr", 32'(bus.adr_o), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    tick();

    // Zero-wait read
    ack_en = 1'b1; wait_n = 8'd0; dev_rdata = 8'hA5;
    issue(1'b0, 8'h10, 8'hEE, 1'b1, '{rdata: 8'hA5, to: 1'b0});
    run_bus("zw_read", 1'b0, 8'h10, 8'h00, 2);
    check("zw_read_ready_resp", 32'(bus.req_ready), 32'd1);
    tick(); tick();

    // Stalled write, three wait states
    wait_n = 8'd3; dev_rdata = 8'h99;
    issue(1'b1, 8'h22, 8'h3C, 1'b1, '{rdata: 8'h00, to: 1'b0});
    run_bus("st_write", 1'b1, 8'h22, 8'h3C, 5);
    tick(); tick();

    // Timeout, then a stray ack while idle
    ack_en = 1'b0; dev_rdata = 8'h77;
    issue(1'b0, 8'h30, 8'h00, 1'b1, '{rdata: 8'h00, to: 1'b1});
    run_bus("timeout", 1'b0, 8'h30, 8'h00, 15);
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick(); tick();
    check("late_ack_cyc", 32'(bus.cyc_o), 32'd0);
    check("late_ack_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Ack first sampled at the timeout edge
    ack_en = 1'b1; wait_n = 8'd13; dev_rdata = 8'h5A;
    issue(1'b0, 8'h55, 8'h00, 1'b1, '{rdata: 8'h5A, to: 1'b0});
    run_bus("ack_at_to", 1'b0, 8'h55, 8'h00, 15);
    tick(); tick();

    // Reset in the second cycle of a stalled read: no response expected
    ack_en = 1'b0;
    issue(1'b0, 8'h66, 8'h00, 1'b0, '{rdata: 8'h00, to: 1'b0});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("mid_rst_stb", 32'(bus.stb_o), 32'd0);
    check("mid_rst_we", 32'(bus.we_o), 32'd0);
    check("mid_rst_adr", 32'(bus.adr_o), 32'd0);
    check("mid_rst_dat", 32'(bus.dat_o), 32'd0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    check("mid_rst_resp_timeout", 32'(bus.resp_timeout), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    tick(); tick(); tick();

    // Back-to-back: req held high, address changes after first accept
    ack_en = 1'b1; wait_n = 8'd0; dev_rdata = 8'h66;
    exp_q.push_back('{rdata: 8'h66, to: 1'b0});
    exp_q.push_back('{rdata: 8'hC3, to: 1'b0});
    exp_cyc = 6'b011011;
    exp_rdy = 6'b100100;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_adr = 8'h40;
    $display("req: b2b adr=0x40 then adr=0x41");
    tick();
    bus.req_adr = 8'h41;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) bus.req = 1'b0;
      check($sformatf("b2b_cyc_c%0d", c), 32'(bus.cyc_o), 32'(exp_cyc[c]));
      check($sformatf("b2b_ready_c%0d", c), 32'(bus.req_ready), 32'(exp_rdy[c]));
      check($sformatf("b2b_resp_c%0d", c), 32'(bus.resp_valid), 32'(exp_rdy[c]));
      if (exp_cyc[c]) check($sformatf("b2b_adr_c%0d", c), 32'(bus.adr_o), (c <= 2) ? 32'h40 : 32'h41);
      tick();
    end
    tick(); tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_ctrl_classic.md
# wishbone_ctrl_classic

Wishbone B4 Classic controller adapter: the upstream counterpart of our Classic device-side adapter. It turns a simple single-transfer request (address, write enable, write data) into one Classic read or write cycle and returns a one-cycle response pulse carrying read data or a timeout flag. It sits between internal command sources (debug bridge, simple sequencers) and the Wishbone interconnect, and drives device adapters directly.

## Interface
- `DAT_WIDTH`, 8: data bus width.
- `ADR_WIDTH`, 8: address bus width.
- `TIMEOUT`, 15: cycles a bus cycle may wait for ack before abort; 0 disables the timeout.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req` input 1: request; accepted on an edge where `req && req_ready`.
- `req_ready` output 1: adapter can accept a request.
- `req_we` input 1: 1 = write, 0 = read; sampled at accept.
- `req_adr` input ADR_WIDTH: address; sampled at accept.
- `req_wdata` input DAT_WIDTH: write data; sampled at accept.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output DAT_WIDTH: read data; 0 for writes and timeouts.
- `resp_timeout` output 1: the cycle was aborted by timeout.
- `cyc_o`, `stb_o` output 1 each: Wishbone cycle and strobe.
- `we_o` output 1: Wishbone write enable.
- `adr_o` output ADR_WIDTH: Wishbone address.
- `dat_o` output DAT_WIDTH: Wishbone write data.
- `dat_i` input DAT_WIDTH: Wishbone read data.
- `ack_i` input 1: Wishbone acknowledge.

## Operation
- FSM states: IDLE, ACTIVE.
- **IDLE**
  - `req_ready = !rst_i` (combinational).
  - On accept: register `req_adr` into `adr_o`, `req_we` into `we_o`, and `req_wdata` into `dat_o` (0 for reads).
  - Also on accept: set `cyc_o` and `stb_o` to 1, clear the wait counter, go to ACTIVE.
- **ACTIVE**
  - `req_ready = 0`; `req` is ignored.
  - `cyc_o`, `stb_o`, `we_o`, `adr_o` and `dat_o` hold stable.
  - At each edge, `ack_i` sampled high ends the cycle:
    - clear `cyc_o`, `stb_o` and `we_o`;
    - set `resp_valid` to 1;
    - set `resp_rdata` to `dat_i` for a read, 0 for a write;
    - set `resp_timeout` to 0;
    - go to IDLE.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT:
    - clear `cyc_o`, `stb_o` and `we_o`;
    - set `resp_valid` to 1, `resp_rdata` to 0, `resp_timeout` to 1;
    - go to IDLE.
  - Ack and timeout on the same edge: ack wins, giving a normal response.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates, so it never wraps.
- `ack_i` seen in IDLE is ignored.
- `resp_rdata` and `resp_timeout` hold their value until the next response; they are meaningful only while `resp_valid` is high.
- `resp_valid` is high for exactly one cycle per accepted request.
- `adr_o` and `dat_o` keep their last value in IDLE. This is harmless because `stb_o` is low.

## Timing
- **Reset** (edge with `rst_i` high):
  - `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `resp_valid`, `resp_rdata`, `resp_timeout` and the counter all clear to 0; FSM goes to IDLE.
  - An in-flight cycle is abandoned with no response.
  - `req` is not accepted while `rst_i` is high.
- **Zero-wait device** (ack asserted the cycle after stb):
  - accept at edge 0;
  - `cyc_o`/`stb_o` high in cycles 1–2; `ack_i` high in cycle 2;
  - `resp_valid` and `req_ready` high in cycle 3.
- Each wait-state cycle adds one cycle to this sequence.
- **Back-to-back**: a request accepted at edge 3 raises `cyc_o` in cycle 4. This leaves exactly one idle bus cycle between transfers, which lets a registered device ack clear.
- **Timeout**: `cyc_o` is high for TIMEOUT cycles, then `resp_valid` is high in the following cycle.

## Structure
- In the shared `wishbone_pkg`:
  - typedef enum `wb_ctrl_state_t` {WB_CTRL_IDLE, WB_CTRL_ACTIVE};
  - constant `WB_CTRL_TIMEOUT_DEFAULT` = 15.
- No sub-module. The FSM, capture registers and the saturating counter form one always_ff block plus a small combinational `req_ready`.
- The bench pairs this block with the device adapter.

## Test plan
- **Zero-wait read**: ack tied high in the device, `dat_i`=0xA5, `req_adr`=0x10, `req_we`=0 accepted at edge 0 → `adr_o`=0x10, `cyc_o`/`stb_o` high in cycles 1–2, `resp_valid` in cycle 3 with `resp_rdata`=0xA5 and `resp_timeout`=0.
- **Stalled write**: `req_adr`=0x22, `req_wdata`=0x3C, device acks after 3 wait cycles → `we_o`=1, `dat_o`=0x3C and `adr_o`=0x22 stable throughout; `resp_valid` one cycle after ack; `resp_rdata`=0x00.
- **Timeout**: TIMEOUT=15, ack never asserted → `cyc_o` high for exactly 15 cycles, then `resp_valid`=1, `resp_timeout`=1, `resp_rdata`=0; a late `ack_i` pulse in IDLE produces no response.
- **Ack on timeout edge**: ack first sampled at the 15th edge → normal response with `resp_timeout`=0 and `resp_rdata`=`dat_i`.
- **Reset mid-cycle**: `rst_i` pulsed in the 2nd cycle of a stalled read → all outputs 0 next cycle, no `resp_valid`, `req_ready`=1 the cycle after `rst_i` falls.
- **Back-to-back**: `req` held high with two different addresses → second accepted in cycle 3, `cyc_o` low for exactly one cycle between transfers, `req_ready`=0 throughout ACTIVE, two `resp_valid` pulses with correct data.
